// File: rtl/ring_counter_gen.sv
// Ring / Johnson shift-register sequencer with run-time mode and direction,
// synchronous load, up-sequence position index, wrap pulse and sticky illegal-state flag.
module ring_counter_gen #(
   parameter int WIDTH = 4,
   parameter int PW    = $clog2(2*WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_err,
   output logic [WIDTH-1:0] q,
   output logic [PW-1:0]    pos,
   output logic             wrap,
   output logic             err
);

   localparam logic [WIDTH-1:0] RST_STATE = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] ONES      = '1;

   // Johnson states are thermometer codes: ones anchored at the LSB (0000..1111)
   // or ones anchored at the MSB (1110..1000); ring states are one-hot.
   function automatic logic is_legal(input logic [WIDTH-1:0] v, input logic md);
      logic ok;
      ok = 1'b0;
      if (!md) begin
         for (int i = 0; i < WIDTH; i++)
            if (v == (ONE << i)) ok = 1'b1;
      end else begin
         for (int n = 0; n <= WIDTH; n++)
            if (v == (ONES >> (WIDTH - n))) ok = 1'b1;
         for (int n = 1; n < WIDTH; n++)
            if (v == ~(ONES >> n)) ok = 1'b1;
      end
      return ok;
   endfunction

   function automatic logic [PW-1:0] pos_of(input logic [WIDTH-1:0] v, input logic md);
      logic [PW-1:0] p;
      p = '0;
      if (!md) begin
         for (int i = 0; i < WIDTH; i++)
            if (v == (ONE << i)) p = PW'((i + 1) % WIDTH);
      end else begin
         for (int n = 0; n <= WIDTH; n++)
            if (v == (ONES >> (WIDTH - n))) p = PW'(n + 1);
         for (int n = 1; n < WIDTH; n++)
            if (v == ~(ONES >> n)) p = PW'((2*WIDTH + 1 - n) % (2*WIDTH));
      end
      return p;
   endfunction

   logic [WIDTH-1:0] q_nxt;
   logic             wrap_nxt;
   logic             err_set;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      q_nxt    = q;
      wrap_nxt = 1'b0;
      err_set  = 1'b0;
      if (load) begin
         if (is_legal(load_val, mode)) begin
            q_nxt = load_val;
         end else begin
            q_nxt   = RST_STATE;
            err_set = 1'b1;
         end
      end else if (!is_legal(q, mode)) begin
         q_nxt   = RST_STATE;
         err_set = 1'b1;
      end else if (en) begin
         if (!dir) begin
            q_nxt    = {q[WIDTH-2:0], mode ? ~q[WIDTH-1] : q[WIDTH-1]};
            wrap_nxt = (q_nxt == RST_STATE);
         end else begin
            q_nxt    = {mode ? ~q[0] : q[0], q[WIDTH-1:1]};
            wrap_nxt = (q == RST_STATE);
         end
      end
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= RST_STATE;
         pos  <= '0;
         wrap <= 1'b0;
         err  <= 1'b0;
      end else begin
         q    <= q_nxt;
         pos  <= pos_of(q_nxt, mode);
         wrap <= wrap_nxt;
         // A fresh error wins over clr_err on the same edge.
         err  <= err_set | (err & ~clr_err);
      end
   end

endmodule

// File: tb/tb_ring_counter_gen.sv
// Self-checking bench for ring_counter_gen: sequence-index model compared every cycle,
// plus directed literal expectations from the worked examples.
module tb_ring_counter_gen;

   localparam int W  = 4;
   localparam int PW = $clog2(2*W);
   localparam logic [W-1:0] MSB = {1'b1, {(W-1){1'b0}}};

   logic          clk = 1'b0;
   logic          rst, en, dir, mode, load, clr_err;
   logic [W-1:0]  load_val;
   logic [W-1:0]  q;
   logic [PW-1:0] pos;
   logic          wrap, err;

   int n_pass  = 0;
   int n_total = 0;

   ring_counter_gen #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dir      (dir),
      .mode     (mode),
      .load     (load),
      .load_val (load_val),
      .clr_err  (clr_err),
      .q        (q),
      .pos      (pos),
      .wrap     (wrap),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: the state is described by its index in the up sequence of the current mode.
   function automatic int period(input logic md);
      return md ? 2*W : W;
   endfunction

   function automatic logic [W-1:0] seq_q(input logic md, input int p);
      int all, n;
      all = (1 << W) - 1;
      if (p == 0) return MSB;
      if (!md) return W'(1 << (p - 1));
      if (p <= W + 1) return W'((1 << (p - 1)) - 1);
      n = 2*W + 1 - p;
      return W'(all & ~((1 << (W - n)) - 1));
   endfunction

   function automatic int index_of(input logic md, input logic [W-1:0] v);
      for (int p = 0; p < period(md); p++)
         if (seq_q(md, p) == v) return p;
      return -1;
   endfunction

   logic [W-1:0] m_q;
   int           m_pos;
   logic         m_wrap, m_err;
   bit           m_valid = 1'b0;

   always @(posedge clk) begin : model
      int cur, np, p_len;
      bit new_err;
      if (rst) begin
         m_q = MSB; m_pos = 0; m_wrap = 1'b0; m_err = 1'b0; m_valid = 1'b1;
      end else if (m_valid) begin
         p_len   = period(mode);
         cur     = index_of(mode, m_q);
         new_err = 1'b0;
         m_wrap  = 1'b0;
         if (load) begin
            if (index_of(mode, load_val) < 0) begin m_q = MSB; new_err = 1'b1; end
            else m_q = load_val;
         end else if (cur < 0) begin
            m_q = MSB; new_err = 1'b1;
         end else if (en) begin
            if (!dir) begin np = (cur + 1) % p_len;         m_wrap = (np == 0); end
            else      begin np = (cur + p_len - 1) % p_len; m_wrap = (cur == 0); end
            m_q = seq_q(mode, np);
         end
         if (new_err) m_err = 1'b1;
         else if (clr_err) m_err = 1'b0;
         m_pos = index_of(mode, m_q);
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("model_q",    32'(q),    32'(m_q));
         check("model_pos",  32'(pos),  32'(m_pos));
         check("model_wrap", 32'(wrap), 32'(m_wrap));
         check("model_err",  32'(err),  32'(m_err));
      end
   end

   task automatic drive(input logic r, input logic e, input logic d, input logic md,
                        input logic l, input logic [W-1:0] lv, input logic c);
      rst = r; en = e; dir = d; mode = md; load = l; load_val = lv; clr_err = c;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [W-1:0] eq, input int ep,
                               input logic ew, input logic ee);
      check({tag, "_q"},    32'(q),    32'(eq));
      check({tag, "_pos"},  32'(pos),  32'(ep));
      check({tag, "_wrap"}, 32'(wrap), 32'(ew));
      check({tag, "_err"},  32'(err),  32'(ee));
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = '0; clr_err = 1'b0;

      // Ring up through a full period
      drive(1, 0, 0, 0, 0, 4'b0000, 0);  expect_state("reset", 4'b1000, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);  expect_state("ring_up1", 4'b0001, 1, 0, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);  expect_state("ring_up2", 4'b0010, 2, 0, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);  expect_state("ring_up3", 4'b0100, 3, 0, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);  expect_state("ring_up4", 4'b1000, 0, 1, 0);

      // Johnson down wraps immediately from the reset state
      drive(1, 0, 0, 1, 0, 4'b0000, 0);
      drive(0, 1, 1, 1, 0, 4'b0000, 0);  expect_state("john_dn1", 4'b1100, 7, 1, 0);
      drive(0, 1, 1, 1, 0, 4'b0000, 0);  expect_state("john_dn2", 4'b1110, 6, 0, 0);

      // Hold, then step down
      drive(1, 0, 0, 0, 0, 4'b0000, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 4'b0000, 0); expect_state("hold", 4'b0010, 2, 0, 0);
      end
      drive(0, 1, 1, 0, 0, 4'b0000, 0);  expect_state("ring_dn", 4'b0001, 1, 0, 0);

      // Legal and illegal loads, sticky err and clear
      drive(1, 0, 0, 0, 0, 4'b0000, 0);
      drive(0, 0, 0, 0, 1, 4'b0100, 0);  expect_state("load_ok", 4'b0100, 3, 0, 0);
      drive(0, 1, 0, 0, 1, 4'b0110, 0);  expect_state("load_bad", 4'b1000, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 4'b0000, 0);  expect_state("err_sticky", 4'b1000, 0, 0, 1);
      drive(0, 0, 0, 0, 0, 4'b0000, 1);  expect_state("err_clr", 4'b1000, 0, 0, 0);
      drive(0, 0, 0, 1, 1, 4'b1110, 0);  expect_state("load_john", 4'b1110, 6, 0, 0);

      // Mode change from an illegal state corrects, then stepping resumes
      drive(1, 0, 0, 0, 0, 4'b0000, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);
      drive(0, 1, 0, 1, 0, 4'b0000, 0);  expect_state("mode_fix", 4'b1000, 0, 0, 1);
      drive(0, 1, 0, 1, 0, 4'b0000, 0);  expect_state("mode_step", 4'b0000, 1, 0, 1);

      // Reset beats load and en on the same edge
      drive(1, 1, 0, 0, 1, 4'b0001, 0);  expect_state("rst_prio", 4'b1000, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 4'b0000, 0);  expect_state("rst_resume", 4'b0001, 1, 0, 0);

      // State legal in both modes keeps q and is re-indexed
      drive(0, 0, 0, 1, 0, 4'b0000, 0);  expect_state("reindex", 4'b0001, 2, 0, 0);

      // Direction toggling every edge with en held
      drive(0, 1, 0, 1, 0, 4'b0000, 0);  expect_state("tog_up", 4'b0011, 3, 0, 0);
      drive(0, 1, 1, 1, 0, 4'b0000, 0);  expect_state("tog_dn", 4'b0001, 2, 0, 0);

      // Mixed traffic, checked against the model every cycle
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 99);
         drive(r < 2, $urandom_range(0, 3) != 0, 1'($urandom),
               ($urandom_range(0, 15) == 0) ? ~mode : mode,
               (r >= 2) && (r < 10), W'($urandom), $urandom_range(0, 7) == 0);
      end

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
